// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter sharing the TX path between frame sources, one grant per frame,
// with a forced inter-frame gap, a hold watchdog and abort on clock change or link loss.
module tx_frame_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned IFG_CYCLES      = 12,
    parameter int unsigned WATCHDOG_CYCLES = 4096,
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned GAP_W = $clog2(IFG_CYCLES + 1),
    localparam int unsigned WD_W  = $clog2(WATCHDOG_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               link_up,
    input  logic               changing,
    input  logic [NUM_REQ-1:0] req,
    input  logic               tx_done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               tx_start,
    output logic               tx_abort,
    output logic               timeout,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               eligible;

    // Search upward from the last grant, wrapping, so every source gets its turn.
    always_comb begin
        winner = grant_idx;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(grant_idx) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign eligible = link_up && !changing && found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            grant     <= '0;
            grant_idx <= IDX_W'(NUM_REQ - 1);
            tx_start  <= 1'b0;
            tx_abort  <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            gap_cnt   <= '0;
            wd_cnt    <= '0;
        end else begin
            tx_start <= 1'b0;
            tx_abort <= 1'b0;
            timeout  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (eligible) begin
                        grant     <= NUM_REQ'(1) << winner;
                        grant_idx <= winner;
                        tx_start  <= 1'b1;
                        busy      <= 1'b1;
                        wd_cnt    <= WD_W'(WATCHDOG_CYCLES - 1);
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Normal completion wins over abort and timeout in the same cycle.
                    if (tx_done || changing || !link_up || wd_cnt == '0) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        gap_cnt <= GAP_W'(IFG_CYCLES - 1);
                        state   <= S_GAP;
                        if (!tx_done) begin
                            if (changing || !link_up) begin
                                tx_abort <= 1'b1;
                            end else begin
                                timeout <= 1'b1;
                            end
                        end
                    end else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: stimulus queues expected grant/release events,
// a negedge monitor pops and compares them, including grant-high and grant-low lengths.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       link_up = 1'b0;
    logic       changing = 1'b0;
    logic       tx_done = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] grant;
    logic       grant_idx;
    logic       tx_start;
    logic       tx_abort;
    logic       timeout;
    logic       busy;

    tx_frame_arbiter #(
        .NUM_REQ        (2),
        .IFG_CYCLES     (12),
        .WATCHDOG_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .link_up  (link_up),
        .changing (changing),
        .req      (req),
        .tx_done  (tx_done),
        .grant    (grant),
        .grant_idx(grant_idx),
        .tx_start (tx_start),
        .tx_abort (tx_abort),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Event record: {grant[1:0], grant_idx, tx_start, tx_abort, timeout, busy}; len < 0 = don't care
    typedef struct {
        logic [6:0] bits;
        int         len;
    } ev_t;

    ev_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_start(input logic idx, input int len);
        ev_t e;
        e.bits = {(idx ? 2'b10 : 2'b01), idx, 1'b1, 1'b0, 1'b0, 1'b1};
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic exp_release(input logic idx, input logic abrt, input logic tmo, input int len);
        ev_t e;
        e.bits = {2'b00, idx, 1'b0, abrt, tmo, 1'b0};
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // Monitor: every grant rise/fall or pulse is an event to be matched against the queue.
    logic [1:0] prev_grant = 2'b00;
    int         hi_len = 0;
    int         lo_len = 0;
    int         ev_len;
    logic       is_ev;
    logic [6:0] obs;
    ev_t        e_pop;

    always @(negedge clk) begin
        chk("grant_onehot", int'($countones(grant) <= 1), 1);
        chk("busy_matches_grant", int'(busy), int'(grant != 2'b00));
        obs    = {grant, grant_idx, tx_start, tx_abort, timeout, busy};
        is_ev  = tx_start || tx_abort || timeout || (prev_grant != 2'b00 && grant == 2'b00);
        ev_len = (grant != 2'b00) ? lo_len : hi_len;
        if (is_ev) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got 0x%0h expected no event", obs);
            end else begin
                e_pop = exp_q.pop_front();
                chk("event_outputs", int'(obs), int'(e_pop.bits));
                if (e_pop.len >= 0) chk("event_length", ev_len, e_pop.len);
            end
        end
        if (grant != 2'b00) begin
            hi_len = (prev_grant == 2'b00) ? 1 : hi_len + 1;
            lo_len = 0;
        end else begin
            lo_len = (prev_grant != 2'b00) ? 1 : lo_len + 1;
        end
        prev_grant = grant;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        for (int i = 1; i <= 300; i++) begin
            cyc(1);
            if (tx_start) begin
                n = i;
                return;
            end
        end
        n = -1;
        chk("start_wait_expired", 0, 1);
    endtask

    int lat;

    initial begin
        cyc(3);
        chk("reset_grant", int'(grant), 0);
        chk("reset_grant_idx", int'(grant_idx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pulses", int'({tx_start, tx_abort, timeout}), 0);

        // Single requester: 1-cycle grant latency, release on tx_done
        reset   = 1'b0;
        link_up = 1'b1;
        req     = 2'b01;
        exp_start(1'b0, -1);
        wait_start(lat);
        chk("grant_latency", lat, 1);
        cyc(2);
        exp_release(1'b0, 1'b0, 1'b0, 3);
        tx_done = 1'b1;
        req     = 2'b11;
        cyc(1);
        tx_done = 1'b0;

        // Both requesting: alternate, 13 grant-low cycles between frames
        for (int i = 0; i < 4; i++) begin
            exp_start((i % 2) == 0, 13);
            wait_start(lat);
            cyc(5);
            exp_release((i % 2) == 0, 1'b0, 1'b0, 6);
            tx_done = 1'b1;
            cyc(1);
            tx_done = 1'b0;
        end

        // Abort by changing; no grant while changing; next grant goes to the other source
        exp_start(1'b1, 13);
        wait_start(lat);
        cyc(2);
        changing = 1'b1;
        exp_release(1'b1, 1'b1, 1'b0, 3);
        cyc(30);
        exp_start(1'b0, 30);
        changing = 1'b0;
        wait_start(lat);

        // Watchdog: no tx_done, grant held 16 cycles then timeout
        exp_release(1'b0, 1'b0, 1'b1, 16);
        cyc(20);

        // tx_done together with changing: plain completion
        exp_start(1'b1, 13);
        wait_start(lat);
        cyc(2);
        tx_done  = 1'b1;
        changing = 1'b1;
        exp_release(1'b1, 1'b0, 1'b0, 3);
        cyc(1);
        tx_done  = 1'b0;
        changing = 1'b0;

        // Link down with both requesting: no grant at all
        link_up = 1'b0;
        cyc(100);
        chk("link_down_grant", int'(grant), 0);
        link_up = 1'b1;
        exp_start(1'b0, -1);
        wait_start(lat);

        // Reset mid-frame: grant drops, no abort, grant_idx back to 1
        cyc(3);
        reset = 1'b1;
        exp_release(1'b1, 1'b0, 1'b0, 4);
        cyc(2);
        chk("reset_mid_grant", int'(grant), 0);
        chk("reset_mid_idx", int'(grant_idx), 1);
        chk("reset_mid_abort", int'(tx_abort), 0);
        reset = 1'b0;

        // After reset source 0 wins first again
        exp_start(1'b0, -1);
        wait_start(lat);
        exp_release(1'b0, 1'b0, 1'b0, 1);
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        req     = 2'b00;
        cyc(20);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test expected finish before 100000ns");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single RGMII transmit path between NUM_REQ frame sources, e.g. port 0 = repeated RX frames and port 1 = locally generated frames.
- Grants one requester at a time, round-robin, and holds the grant for a whole frame.
- Enforces a minimum inter-frame gap between frames.
- Blocks new grants, and aborts any frame in flight, while the TX clock/speed is being changed or the link is down.
- Sits between the frame sources and the TX MAC, in the clk domain of the TX clock manager.

Parameters:
- NUM_REQ, 2, number of requesters; legal range ≥2.
- IFG_CYCLES, 12, idle clk cycles forced between two grants; legal range ≥1.
- WATCHDOG_CYCLES, 4096, maximum clk cycles a grant may be held before forced release; legal range ≥2.

Ports:
- clk  input  1  module clock.
- reset  input  1  synchronous, active-high.
- link_up  input  1  stable link status from the TX clock manager.
- changing  input  1  high while the TX clock manager is resetting or reconfiguring TX.
- req  input  NUM_REQ  level request per source; bit i = source i.
- tx_done  input  1  one-cycle pulse from the TX MAC at end of frame.
- grant  output  NUM_REQ  one-hot grant; all zero when nobody is granted.
- grant_idx  output  $clog2(NUM_REQ)  index of the current or last grant.
- tx_start  output  1  one-cycle pulse on the first cycle of a grant.
- tx_abort  output  1  one-cycle pulse when a grant is revoked by changing or !link_up.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant.
- busy  output  1  high in S_BUSY.

Behaviour:
- All outputs are registered.

Reset:
- grant=0, grant_idx=NUM_REQ-1 (so req[0] wins first), tx_start=0, tx_abort=0, timeout=0, busy=0.
- state=S_IDLE; counters cleared.
- Reset mid-frame drops grant on the next edge; no tx_abort pulse is issued.

States:
- S_IDLE
  - Eligible when link_up && !changing && |req.
  - Winner = first set req bit searching upward from grant_idx+1, wrapping modulo NUM_REQ.
  - Next cycle: grant=onehot(winner), grant_idx=winner, tx_start=1 for one cycle, busy=1, watchdog=WATCHDOG_CYCLES-1, state S_BUSY.
  - Latency from req sampled to grant visible: 1 cycle.
- S_BUSY
  - Grant is held regardless of req; a requester dropping req is ignored.
  - Priority, highest first:
    1. tx_done → grant=0, busy=0, S_GAP.
    2. changing || !link_up → grant=0, tx_abort pulse, S_GAP.
    3. watchdog==0 → grant=0, timeout pulse, S_GAP.
    4. Otherwise decrement watchdog.
  - Simultaneous tx_done and abort/timeout conditions: only the normal completion is taken; no tx_abort or timeout pulse.
  - Entering S_GAP loads gap counter=IFG_CYCLES-1.
- S_GAP
  - Decrement the gap counter each cycle; at 0 go to S_IDLE.
  - changing or link loss does not extend the gap; S_IDLE gates eligibility.
- tx_done outside S_BUSY is ignored.

Timing and widths:
- Minimum grant-low time between consecutive grants = IFG_CYCLES+1 cycles (IFG_CYCLES in S_GAP plus 1 in S_IDLE).
- Gap counter width = $clog2(IFG_CYCLES+1).
- Watchdog counter width = $clog2(WATCHDOG_CYCLES+1).
- Decrements never underflow: the counter is only decremented when nonzero.

Fairness:
- With all requesters continuously asserting, grants rotate 0,1,…,NUM_REQ-1,0,…
- grant_idx is updated only on a new grant; it is not cleared on release.

Invariant: grant is always zero or one-hot.

Test Plan:
- Reset, then link_up=1, changing=0, req=2'b01 → next cycle grant=01, tx_start=1 for 1 cycle, busy=1; tx_done pulse → grant=00 next cycle.
- req=2'b11 held, tx_done 5 cycles after each tx_start, IFG_CYCLES=12 → grants alternate 01,10,01,10; grant low for exactly 13 cycles between frames.
- During S_BUSY raise changing=1 → grant=00 and tx_abort pulse on the next cycle; no new grant while changing=1; after changing=0, the next grant goes to the next requester after the aborted one.
- WATCHDOG_CYCLES=16, no tx_done → grant held exactly 16 cycles, then grant=00 with timeout pulse.
- tx_done and changing asserted in the same cycle in S_BUSY → grant=00, tx_abort=0, timeout=0.
- link_up=0 with req=2'b11 for 100 cycles → grant stays 00; reset asserted mid-frame → grant=00, tx_abort=0, grant_idx=1.
